// File: rtl/cp2_rx_port_if.sv
// rtl/cp2_rx_port_if.sv - MEM-stage write channel and CP2 stream bundle for cp2_rx_port
// slave is the receiving port's view; master is the producer/consumer side.
interface cp2_rx_port_if #(
  parameter int DATA_W = 32
);
  logic              cp2_tds;
  logic [DATA_W-1:0] cp2_tdata;
  logic              cp2_tlast;
  logic              cp2_busy;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;

  modport slave (
    input  cp2_tds, cp2_tdata, cp2_tlast, m_tready,
    output cp2_busy, m_tvalid, m_tdata, m_tlast
  );

  modport master (
    output cp2_tds, cp2_tdata, cp2_tlast, m_tready,
    input  cp2_busy, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/cp2_rx_port.sv
// rtl/cp2_rx_port.sv - CP2 receive port: show-ahead FIFO, almost-full busy, frame counter
// Words are stored as {tlast, tdata}; level is tracked explicitly alongside the pointers.
module cp2_rx_port #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2,
  parameter int FCNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  cp2_rx_port_if.slave             bus,
  input  logic                     clr_err,
  output logic                     ovf_err,
  output logic [FCNT_W-1:0]        frame_cnt,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(DEPTH - AFULL_MARGIN);

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [DATA_W:0]   head;
  logic              rd_en, wr_en, not_empty;

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (level_q != '0);

  always_comb begin
    rd_en    = not_empty && bus.m_tready;
    // A full FIFO still takes a word when a slot frees up in the same cycle.
    wr_en    = bus.cp2_tds && ((level_q != FULL_LVL) || rd_en);
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d  = level_q;
    if (wr_en && !rd_en) begin
      level_d = level_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      level_d = level_q - 1'b1;
    end
    busy_d = (level_d >= AFULL_LVL);
    ovf_d  = ovf_q;
    if (bus.cp2_tds && !wr_en) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end
    fcnt_d = (rd_en && head[DATA_W]) ? fcnt_q + 1'b1 : fcnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Storage needs no reset; entries are only observed while level is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= {bus.cp2_tlast, bus.cp2_tdata};
    end
  end

  assign bus.m_tvalid = not_empty;
  assign bus.m_tdata  = head[DATA_W-1:0];
  assign bus.m_tlast  = head[DATA_W] & not_empty;
  assign bus.cp2_busy = busy_q;
  assign ovf_err      = ovf_q;
  assign frame_cnt    = fcnt_q;
  assign level        = level_q;
endmodule

// File: tb/tb_cp2_rx_port.sv
// tb/tb_cp2_rx_port.sv - scoreboard bench for cp2_rx_port
module tb_cp2_rx_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        clr_err;
  logic        ovf_err;
  logic [15:0] frame_cnt;
  logic [3:0]  level;

  int tests = 0;
  int fails = 0;
  int exp_frames = 0;
  logic [32:0] exp_q [$];

  cp2_rx_port_if #(.DATA_W(32)) bus ();

  cp2_rx_port #(.DATA_W(32), .DEPTH(8), .AFULL_MARGIN(2), .FCNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clr_err   (clr_err),
    .ovf_err   (ovf_err),
    .frame_cnt (frame_cnt),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one write this cycle; accepted words go to the scoreboard.
  task automatic wr(input logic [31:0] d, input logic last, input bit expect_accept);
    bus.cp2_tds   = 1'b1;
    bus.cp2_tdata = d;
    bus.cp2_tlast = last;
    if (expect_accept) exp_q.push_back({last, d});
    tick();
    bus.cp2_tds   = 1'b0;
    bus.cp2_tlast = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    bus.m_tready = 1'b1;
    n = 0;
    while ((level != 0 || exp_q.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_drain_done"}, 32'(exp_q.size() == 0 && level == 0), 32'd1);
    tick();
  endtask

  // Monitor: compare every handshake against the scoreboard head.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.m_tvalid && bus.m_tready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra: got %0h/%0b expected no word", bus.m_tdata, bus.m_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({bus.m_tlast, bus.m_tdata} !== e) begin
            fails++;
            $display("FAIL stream_word: got %0b/%0h expected %0b/%0h",
                     bus.m_tlast, bus.m_tdata, e[32], e[31:0]);
          end
          if (e[32]) exp_frames++;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    clr_err = 1'b0;
    bus.cp2_tds = 1'b0;
    bus.cp2_tdata = '0;
    bus.cp2_tlast = 1'b0;
    bus.m_tready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1: reset then idle
    chk("rst_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(bus.cp2_busy), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_tlast", 32'(bus.m_tlast), 32'd0);

    // 2: three-word frame, consumer always ready
    bus.m_tready = 1'b1;
    bus.cp2_tds = 1'b1;
    bus.cp2_tdata = 32'hA0;
    #1;
    chk("no_bypass", 32'(bus.m_tvalid), 32'd0);
    bus.cp2_tds = 1'b0;
    wr(32'hA0, 1'b0, 1'b1);
    chk("latency1", 32'(bus.m_tvalid), 32'd1);
    wr(32'hA1, 1'b0, 1'b1);
    wr(32'hA2, 1'b1, 1'b1);
    drain("t2");
    chk("t2_fcnt", 32'(frame_cnt), 32'd1);
    chk("t2_fcnt_model", 32'(frame_cnt), 32'(exp_frames));
    chk("t2_level", 32'(level), 32'd0);

    // 3: fill with consumer stalled; busy rises once level reaches 6
    bus.m_tready = 1'b0;
    for (int i = 0; i < 5; i++) wr(32'hB0 + 32'(i), 1'b0, 1'b1);
    chk("t3_busy_at5", 32'(bus.cp2_busy), 32'd0);
    wr(32'hB5, 1'b0, 1'b1);
    chk("t3_busy_at6", 32'(bus.cp2_busy), 32'd1);
    chk("t3_level6", 32'(level), 32'd6);
    wr(32'hB6, 1'b0, 1'b1);
    wr(32'hB7, 1'b1, 1'b1);
    chk("t3_level8", 32'(level), 32'd8);

    // 4: overflow drop, sticky error, clear, drain originals
    wr(32'hDEAD, 1'b0, 1'b0);
    chk("t4_ovf", 32'(ovf_err), 32'd1);
    chk("t4_level", 32'(level), 32'd8);
    tick();
    chk("t4_ovf_sticky", 32'(ovf_err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_ovf_clr", 32'(ovf_err), 32'd0);
    drain("t4");
    chk("t4_fcnt", 32'(frame_cnt), 32'd2);
    chk("t4_busy_off", 32'(bus.cp2_busy), 32'd0);

    // 5: full with simultaneous read and write
    bus.m_tready = 1'b0;
    for (int i = 0; i < 8; i++) wr(32'hC0 + 32'(i), 1'b0, 1'b1);
    chk("t5_full", 32'(level), 32'd8);
    bus.m_tready = 1'b1;
    wr(32'hC8, 1'b1, 1'b1);
    bus.m_tready = 1'b0;
    chk("t5_level", 32'(level), 32'd8);
    chk("t5_ovf", 32'(ovf_err), 32'd0);
    drain("t5");
    chk("t5_fcnt", 32'(frame_cnt), 32'd3);
    chk("t5_fcnt_model", 32'(frame_cnt), 32'(exp_frames));

    // 6: reset mid-frame discards buffered words
    bus.m_tready = 1'b0;
    for (int i = 0; i < 5; i++) wr(32'hE0 + 32'(i), 1'b0, 1'b1);
    chk("t6_level5", 32'(level), 32'd5);
    reset = 1'b1;
    exp_q.delete();
    exp_frames = 0;
    tick();
    reset = 1'b0;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("t6_fcnt", 32'(frame_cnt), 32'd0);
    chk("t6_busy", 32'(bus.cp2_busy), 32'd0);
    bus.m_tready = 1'b1;
    wr(32'h5A5A5A5A, 1'b1, 1'b1);
    drain("t6");
    chk("t6_fcnt_after", 32'(frame_cnt), 32'd1);
    chk("t6_fcnt_model", 32'(frame_cnt), 32'(exp_frames));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cp2_rx_port.md
Name: cp2_rx_port

Overview:
- Receiving end of the coprocessor-2 transmit channel driven by the MEM stage (cp2_tdata_0 / cp2_tds_0, plus the frame-end flag taken from mem_cp2_fs_0).
- Buffers words in a show-ahead FIFO and presents them to the CP2 datapath over a valid/ready stream with a last-word marker.
- Back-pressures the pipeline through cp2_busy, which feeds the pipeline stall logic, early enough to absorb in-flight words.
- Counts completed frames and flags overflow.

Parameters:
- DATA_W, 32, width of a transferred word (matches WORDDATABUS).
- DEPTH, 8, FIFO entries; power of two, at least 4.
- AFULL_MARGIN, 2, free entries remaining at which cp2_busy asserts.
- FCNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  reset, synchronous, active-high.
- cp2_tds  in  1  write strobe from the MEM stage; one word per cycle when high.
- cp2_tdata  in  DATA_W  word written when cp2_tds=1.
- cp2_tlast  in  1  marks the word as the last of a frame; sampled with cp2_tds.
- cp2_busy  out  1  almost-full back-pressure to the pipeline stall logic.
- m_tvalid  out  1  stream word available.
- m_tready  in  1  consumer accepts the word.
- m_tdata  out  DATA_W  stream word.
- m_tlast  out  1  stream last-of-frame marker.
- clr_err  in  1  clears ovf_err.
- ovf_err  out  1  sticky; a write was dropped because the FIFO was full.
- frame_cnt  out  FCNT_W  frames fully delivered downstream.
- level  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (synchronous, active-high, takes priority over every other input) clears:
  - rd_ptr, wr_ptr and level to 0;
  - m_tvalid and m_tlast to 0;
  - cp2_busy and ovf_err to 0;
  - frame_cnt to 0.
  - m_tdata content is don't-care while m_tvalid=0.
- Storage is DEPTH x (DATA_W+1) entries holding {tlast, tdata}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is tracked explicitly.
- Write: cp2_tds=1 and (level<DEPTH or a read occurs in the same cycle) → entry stored at wr_ptr, wr_ptr+1.
- Read: handshake is m_tvalid & m_tready → rd_ptr+1.
- Show-ahead output:
  - m_tvalid = (level!=0).
  - m_tdata and m_tlast come combinationally from entry[rd_ptr].
  - Write-to-visible latency is 1 cycle: a strobe at edge N makes m_tvalid=1 after edge N.
  - There is no same-cycle bypass when the FIFO is empty.
- level update: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with simultaneous read and write: the write is accepted and level stays DEPTH.
- Full with write and no read: the word is dropped, nothing in the FIFO changes, and ovf_err is set at the next edge.
- ovf_err: set has priority over clr_err in the same cycle; otherwise clr_err=1 clears it.
- Empty with m_tready=1: no read and no pointer movement.
- cp2_busy is registered; the next value is (level_next >= DEPTH-AFULL_MARGIN). With defaults it asserts at level ≥ 6, guaranteeing that 2 in-flight words still fit.
- frame_cnt increments on each handshake where m_tlast=1. It wraps to 0 from all-ones.
- There is no state machine beyond the pointer/level logic.
- The MEM stage must hold cp2_tds low while cp2_busy=1. Words written regardless are still accepted until the FIFO is full.
- Reset asserted mid-frame discards all buffered words and partial frames. frame_cnt does not count the discarded frames.

Test Plan:
1. Reset then idle: m_tvalid=0, level=0, cp2_busy=0, frame_cnt=0.
2. Write A0,A1,A2 (tlast on A2) with m_tready=1:
   - m_tvalid rises 1 cycle after the first strobe;
   - A0,A1,A2 emerge in order;
   - m_tlast=1 only with A2;
   - frame_cnt=1;
   - level returns to 0.
3. With m_tready=0, write 6 words: cp2_busy=1 after the 6th write edge; a 7th and 8th write are accepted and level=8.
4. With the FIFO full and m_tready=0, write a 9th word: it is dropped and ovf_err=1. Pulse clr_err: ovf_err=0. Drain yields exactly the 8 original words.
5. With the FIFO full, assert cp2_tds=1 and m_tready=1 in the same cycle: level stays 8, ovf_err stays 0, and the new word appears last in order.
6. With 5 words buffered mid-frame, assert reset for 1 cycle: level=0, m_tvalid=0, frame_cnt unchanged from its reset value (0), cp2_busy=0. A subsequent single-word frame delivers correctly.
